dct_ft_stream: RTL and testbench

Streaming 1-D forward DCT row stage with full valid/ready flow control.
- Wraps the team's fixed-latency 1-D DCT math core, which has no stall input.
- A credit counter and an output FIFO make the stage tolerate downstream backpressure without losing beats in the non-stallable core.
- Generalised input sample width and optional JPEG level shift.
- Adds block-framing checking: 8 rows per block, with sob/eob alignment.

---
 rtl/dct_ft_stream.sv | 212 +++++++++++++++++++++
 tb/tb_dct_ft_stream.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_ft_stream.sv
// Streaming 1-D forward DCT row stage: non-stallable fixed-latency core, credit-gated
// input, show-ahead output FIFO and 8-row block framing checker.
module dct_ft_stream #(
  parameter int unsigned IN_W        = 8,
  parameter int unsigned MATH_LAT    = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned LEVEL_SHIFT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0][IN_W-1:0]          in_data,
  input  logic                          in_sob,
  input  logic                          in_eob,
  input  logic                          in_sof,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [7:0][15:0]       out_data,
  output logic                          out_sob,
  output logic                          out_eob,
  output logic                          out_sof,
  output logic                          err_frame,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 131;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [IN_W:0] SHIFT = (LEVEL_SHIFT != 0) ? {2'b01, {(IN_W-1){1'b0}}} : '0;

  typedef logic [7:0][15:0] row_t;
  typedef enum logic {IDLE, IN_BLK} state_t;

  // Basis coefficient 0.5*c(k)*cos((2n+1)k*pi/16) in Q12, folded onto the first quadrant.
  function automatic logic signed [15:0] coef(input int unsigned k, input int unsigned n);
    int unsigned m;
    logic signed [15:0] mag;
    logic neg;
    m   = ((2*n + 1) * k) % 32;
    neg = 1'b0;
    if (m > 16) m = 32 - m;
    if (m > 8) begin
      m   = 16 - m;
      neg = 1'b1;
    end
    case (m)
      0:       mag = 16'sd2048;
      1:       mag = 16'sd2009;
      2:       mag = 16'sd1892;
      3:       mag = 16'sd1703;
      4:       mag = 16'sd1448;
      5:       mag = 16'sd1138;
      6:       mag = 16'sd784;
      7:       mag = 16'sd400;
      default: mag = '0;
    endcase
    if (k == 0) mag = 16'sd1448;
    coef = neg ? -mag : mag;
  endfunction

  logic acc, pop, wr_en;
  logic [EW-1:0] wdata, head;

  logic signed [IN_W:0] core_in [8];
  logic signed [31:0]   dot [8];
  logic signed [31:0]   rnd [8];
  row_t                 core_row;

  row_t       core_pipe_q [MATH_LAT];
  row_t       core_pipe_d [MATH_LAT];
  logic [3:0] flag_pipe_q [MATH_LAT];
  logic [3:0] flag_pipe_d [MATH_LAT];

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d, used_q, used_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [EW-1:0] out_ent_q, out_ent_d;

  state_t     state_q;
  logic [2:0] row_cnt_q;
  logic       err_frame_q;

  assign acc   = in_valid & in_ready_q;
  assign pop   = out_valid_q & out_ready;
  assign wr_en = flag_pipe_q[MATH_LAT-1][3];
  assign wdata = {core_pipe_q[MATH_LAT-1], flag_pipe_q[MATH_LAT-1][2:0]};

  always_comb begin
    for (int unsigned n = 0; n < 8; n++) begin
      core_in[n] = $signed({1'b0, in_data[n]} - SHIFT);
    end
    for (int unsigned k = 0; k < 8; k++) begin
      dot[k] = '0;
      for (int unsigned n = 0; n < 8; n++) begin
        dot[k] = dot[k] + 32'(core_in[n]) * 32'(coef(k, n));
      end
      rnd[k] = (dot[k] + 32'sd2048) >>> 12;
      if (rnd[k] > 32'sd32767)       core_row[k] = 16'h7fff;
      else if (rnd[k] < -32'sd32768) core_row[k] = 16'h8000;
      else                           core_row[k] = rnd[k][15:0];
    end
  end

  // The core never stalls; rows are tagged with acc and only tagged rows reach the FIFO.
  always_comb begin
    core_pipe_d[0] = core_row;
    flag_pipe_d[0] = {acc, in_sob, in_eob, in_sof};
    for (int unsigned i = 1; i < MATH_LAT; i++) begin
      core_pipe_d[i] = core_pipe_q[i-1];
      flag_pipe_d[i] = flag_pipe_q[i-1];
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(wr_en);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    cnt_d       = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    used_d      = used_q + (AW+1)'(acc) - (AW+1)'(pop);
    in_ready_d  = used_d < DEPTH_C;
    out_valid_d = cnt_d != '0;
    // A write landing on the new head slot bypasses the memory so show-ahead holds.
    head        = (wr_en && wr_ptr_q == rd_ptr_d) ? wdata : mem_q[rd_ptr_d];
    out_ent_d   = out_valid_d ? head : out_ent_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MATH_LAT; i++) begin
        core_pipe_q[i] <= '0;
        flag_pipe_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      used_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_ent_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < MATH_LAT; i++) begin
        core_pipe_q[i] <= core_pipe_d[i];
        flag_pipe_q[i] <= flag_pipe_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      used_q      <= used_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_ent_q   <= out_ent_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      err_frame_q <= 1'b0;
    end else begin
      err_frame_q <= 1'b0;
      if (acc) begin
        if (in_sof && !in_sob) err_frame_q <= 1'b1;
        case (state_q)
          IDLE: begin
            if (in_sob) begin
              state_q   <= IN_BLK;
              row_cnt_q <= 3'd1;
            end else begin
              err_frame_q <= 1'b1;
            end
          end
          IN_BLK: begin
            if (in_sob) begin
              err_frame_q <= 1'b1;
              row_cnt_q   <= 3'd1;
            end else if (row_cnt_q == 3'd7) begin
              state_q   <= IDLE;
              row_cnt_q <= '0;
              if (!in_eob) err_frame_q <= 1'b1;
            end else if (in_eob) begin
              err_frame_q <= 1'b1;
              state_q     <= IDLE;
              row_cnt_q   <= '0;
            end else begin
              row_cnt_q <= row_cnt_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && cnt_q == DEPTH_C && !pop));

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_ent_q[EW-1:3];
  assign out_sob    = out_ent_q[2];
  assign out_eob    = out_ent_q[1];
  assign out_sof    = out_ent_q[0];
  assign err_frame  = err_frame_q;
  assign fifo_level = cnt_q;

endmodule

// File: tb/tb_dct_ft_stream.sv
// Scoreboard bench for dct_ft_stream: two instances (8-bit level-shifted, 10-bit unshifted)
// checked against a cosine-formula DCT reference.
module tb_dct_ft_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic               in_valid_a = 1'b0, in_ready_a, in_sob_a = 1'b0, in_eob_a = 1'b0, in_sof_a = 1'b0;
  logic [7:0][7:0]    in_data_a = '0;
  logic               out_valid_a, out_ready_a = 1'b0, out_sob_a, out_eob_a, out_sof_a, err_frame_a;
  logic [7:0][15:0]   out_data_a;
  logic [4:0]         fifo_level_a;

  logic               in_valid_b = 1'b0, in_ready_b, in_sob_b = 1'b0, in_eob_b = 1'b0, in_sof_b = 1'b0;
  logic [7:0][9:0]    in_data_b = '0;
  logic               out_valid_b, out_ready_b = 1'b0, out_sob_b, out_eob_b, out_sof_b, err_frame_b;
  logic [7:0][15:0]   out_data_b;
  logic [4:0]         fifo_level_b;

  dct_ft_stream #(.IN_W(8), .MATH_LAT(8), .FIFO_DEPTH(16), .LEVEL_SHIFT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .in_sob(in_sob_a), .in_eob(in_eob_a), .in_sof(in_sof_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .out_sob(out_sob_a), .out_eob(out_eob_a),
    .out_sof(out_sof_a), .err_frame(err_frame_a), .fifo_level(fifo_level_a));

  dct_ft_stream #(.IN_W(10), .MATH_LAT(8), .FIFO_DEPTH(16), .LEVEL_SHIFT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .in_sob(in_sob_b), .in_eob(in_eob_b), .in_sof(in_sof_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_sob(out_sob_b), .out_eob(out_eob_b),
    .out_sof(out_sof_b), .err_frame(err_frame_b), .fifo_level(fifo_level_b));

  int checks = 0, passes = 0;
  int acc_cnt_a = 0, err_cnt = 0, lvl_viol = 0, first_ov = -1, last_acc_cyc = 0, fr_idx = 0;
  int rmode = 1;
  logic [130:0] exp_a [$];
  logic [130:0] exp_b [$];
  longint xa [8];
  longint xb [8];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Orthonormal DCT-II straight from the cosine definition, Q12 basis, round half up.
  function automatic longint basis(input int k, input int n);
    real ck, v;
    ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v  = 2048.0 * ck * $cos(3.14159265358979 * real'((2*n + 1) * k) / 16.0);
    return longint'($rtoi($floor(v + 0.5)));
  endfunction

  function automatic logic [127:0] ref_dct(input longint x [8]);
    logic [7:0][15:0] y;
    longint s, r;
    for (int k = 0; k < 8; k++) begin
      s = 0;
      for (int n = 0; n < 8; n++) s += x[n] * basis(k, n);
      r = (s + 2048) >>> 12;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      y[k] = r[15:0];
    end
    return y;
  endfunction

  task automatic chk(input string nm, input logic [130:0] got, input logic [130:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Recorders: push the reference result for every accepted row.
  always @(negedge clk) begin
    if (rst_n && in_valid_a && in_ready_a) begin
      for (int n = 0; n < 8; n++) xa[n] = longint'(in_data_a[n]) - 128;
      exp_a.push_back({ref_dct(xa), in_sob_a, in_eob_a, in_sof_a});
      acc_cnt_a++;
    end
    if (rst_n && in_valid_b && in_ready_b) begin
      for (int n = 0; n < 8; n++) xb[n] = longint'(in_data_b[n]);
      exp_b.push_back({ref_dct(xb), in_sob_b, in_eob_b, in_sof_b});
    end
  end

  // Monitors: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready_a) begin
      if (exp_a.size() == 0) begin
        checks++;
        $display("FAIL sb_a: unexpected row %h, none expected", out_data_a);
      end else chk("sb_a", {out_data_a, out_sob_a, out_eob_a, out_sof_a}, exp_a.pop_front());
    end
    if (rst_n && out_valid_b && out_ready_b) begin
      if (exp_b.size() == 0) begin
        checks++;
        $display("FAIL sb_b: unexpected row %h, none expected", out_data_b);
      end else chk("sb_b", {out_data_b, out_sob_b, out_eob_b, out_sof_b}, exp_b.pop_front());
    end
    if (fifo_level_a > 5'd16) lvl_viol++;
    if (err_frame_a) err_cnt++;
    if (out_valid_a && first_ov < 0) first_ov = cyc;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rmode == 0) out_ready_a = 1'b0;
    else if (rmode == 1) out_ready_a = 1'b1;
    else out_ready_a = 1'($urandom_range(0, 1));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_row(input logic [7:0][7:0] d, input logic sob, input logic eob, input logic sof);
    int w = 0;
    in_data_a = d; in_sob_a = sob; in_eob_a = eob; in_sof_a = sof; in_valid_a = 1'b1;
    @(negedge clk);
    while (!in_ready_a && w < 500) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready_a) begin
      checks++;
      $display("FAIL send_a timeout: in_ready 0 after %0d cycles, required 1", w);
    end else last_acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
  endtask

  task automatic send_framed(input logic [7:0][7:0] d);
    send_row(d, fr_idx % 8 == 0, fr_idx % 8 == 7, fr_idx % 64 == 0);
    fr_idx++;
  endtask

  task automatic send_row_b(input logic [7:0][9:0] d, input logic sob, input logic eob, input logic sof);
    int w = 0;
    in_data_b = d; in_sob_b = sob; in_eob_b = eob; in_sof_b = sof; in_valid_b = 1'b1;
    @(negedge clk);
    while (!in_ready_b && w < 500) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready_b) begin
      checks++;
      $display("FAIL send_b timeout: in_ready 0 after %0d cycles, required 1", w);
    end
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
  endtask

  task automatic wait_drain(input bit which_b);
    int w = 0;
    while ((which_b ? exp_b.size() : exp_a.size()) != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    #1;
    if ((which_b ? exp_b.size() : exp_a.size()) != 0) begin
      checks++;
      $display("FAIL drain timeout: %0d rows outstanding, required 0",
               which_b ? exp_b.size() : exp_a.size());
    end
  endtask

  function automatic logic [63:0] rand_row();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int base, ov_seen;
    logic [7:0][9:0] rb;

    out_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chki("rst_in_ready", int'(in_ready_a), 1);
    chki("rst_out_valid", int'(out_valid_a), 0);
    chki("rst_fifo_level", int'(fifo_level_a), 0);
    chki("rst_err_frame", int'(err_frame_a), 0);
    chk("rst_out_data", {3'b000, out_data_a}, '0);
    tick(1);

    // Mid-scale rows: zero coefficients, minimum latency, flag alignment.
    err_cnt = 0; fr_idx = 0;
    for (int i = 0; i < 8; i++) begin
      send_framed({8{8'd128}});
      if (i == 0) base = last_acc_cyc;
    end
    wait_drain(1'b0);
    chki("latency", first_ov - base, 9);
    chki("err_t1", err_cnt, 0);

    // Full backpressure: credits cap acceptance at the FIFO depth.
    rmode = 0;
    tick(2);
    base = acc_cnt_a; fr_idx = 0;
    for (int i = 0; i < 16; i++) send_framed(rand_row());
    in_data_a = rand_row(); in_sob_a = 1'b1; in_eob_a = 1'b0; in_sof_a = 1'b0; in_valid_a = 1'b1;
    repeat (30) @(negedge clk);
    chki("acc_16", acc_cnt_a - base, 16);
    chki("full_in_ready", int'(in_ready_a), 0);
    chki("full_level", int'(fifo_level_a), 16);
    rmode = 1;
    @(negedge clk);
    chki("pop_cycle_in_ready", int'(in_ready_a), 0);
    @(negedge clk);
    chki("after_pop_in_ready", int'(in_ready_a), 1);
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    fr_idx = 17;
    for (int i = 0; i < 7; i++) send_framed(rand_row());
    wait_drain(1'b0);
    chki("acc_24", acc_cnt_a - base, 24);

    // Early eob on row 5, then a clean block.
    err_cnt = 0;
    for (int i = 0; i < 6; i++) send_row(rand_row(), i == 0, i == 5, i == 0);
    @(negedge clk);
    chki("err_pulse", int'(err_frame_a), 1);
    @(negedge clk);
    chki("err_clear", int'(err_frame_a), 0);
    tick(1);
    fr_idx = 0;
    for (int i = 0; i < 8; i++) send_framed(rand_row());
    wait_drain(1'b0);
    chki("err_t3_total", err_cnt, 1);

    // Random traffic with random backpressure.
    err_cnt = 0; lvl_viol = 0; fr_idx = 0; rmode = 2;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 2));
      send_framed(rand_row());
    end
    rmode = 1;
    wait_drain(1'b0);
    chki("level_violations", lvl_viol, 0);
    chki("err_t4", err_cnt, 0);

    // Reset with rows in flight.
    rmode = 0;
    tick(2);
    fr_idx = 0;
    for (int i = 0; i < 10; i++) send_framed(rand_row());
    repeat (3) @(negedge clk);
    chki("pre_rst_out_valid", int'(out_valid_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chki("rst2_out_valid", int'(out_valid_a), 0);
    chki("rst2_fifo_level", int'(fifo_level_a), 0);
    chki("rst2_in_ready", int'(in_ready_a), 1);
    exp_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid_a) ov_seen++;
    end
    chki("post_rst_out_valid", ov_seen, 0);
    rmode = 1;
    tick(1);

    // Unshifted 10-bit instance: zero row, single full-scale sample, random rows.
    send_row_b('0, 1'b1, 1'b0, 1'b1);
    rb = '0;
    rb[0] = 10'd1023;
    send_row_b(rb, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 8; i++) begin
      for (int n = 0; n < 8; n++) rb[n] = 10'($urandom);
      send_row_b(rb, 1'b0, i == 7, 1'b0);
    end
    wait_drain(1'b1);
    chki("err_b", int'(err_frame_b), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
